// File: rtl/mcs6530_bus_pkg.sv
// Shared types and default parameters for the MCS6530 bus master.
// FSM and PHI2 phase encodings live here so the generator and the top agree.
package mcs6530_bus_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        IDLE  = 2'd1,
        CYCLE = 2'd2
    } state_t;

    typedef enum logic {
        PH1 = 1'b0,
        PH2 = 1'b1
    } phase_t;

    localparam int DIV_DEF        = 4;
    localparam int RES_CYCLES_DEF = 8;
    localparam int ADDR_W_DEF     = 10;

endpackage

// File: rtl/mcs6530_bus_master_phi2_gen.sv
// Free-running PHI2 generator: DIV system clocks per half-period, PH1 (low) then PH2 (high).
// fall_stb marks the last clk of PH2, end_stb the last clk of PH1.
module phi2_gen
    import mcs6530_bus_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic phi2,
    output logic fall_stb,
    output logic end_stb
);

    localparam int HC_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("phi2_gen: DIV must be 2 or more");
        end
    endgenerate

    logic [HC_W-1:0] hc;
    phase_t          phase;
    logic            hc_last;

    assign hc_last = (hc == HC_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc    <= '0;
            phase <= PH1;
        end else if (hc_last) begin
            hc    <= '0;
            phase <= (phase == PH1) ? PH2 : PH1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    assign phi2     = (phase == PH2);
    assign fall_stb = (phase == PH2) && hc_last;
    assign end_stb  = (phase == PH1) && hc_last;

endmodule

// File: rtl/mcs6530_bus_master.sv
// 6502-side bus initiator for an MCS6530: one PHI2 bus cycle per accepted command,
// address/control launched at PH1 entry, read data captured on the PHI2 fall clk.
module mcs6530_bus_master
    import mcs6530_bus_pkg::*;
#(
    parameter int DIV        = DIV_DEF,
    parameter int RES_CYCLES = RES_CYCLES_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic              cmd_rs0,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [7:0]        rsp_rdata,
    output logic              phi2_o,
    output logic              res_n_o,
    output logic              rw_o,
    output logic              rs0_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        db_o,
    output logic              db_oe,
    input  logic [7:0]        db_i,
    output logic              busy
);

    localparam int RC_W = $clog2(RES_CYCLES + 1);
    localparam logic [RC_W-1:0] RES_LAST = RC_W'(RES_CYCLES - 1);

    generate
        if (RES_CYCLES < 1) begin : g_res_check
            $error("mcs6530_bus_master: RES_CYCLES must be 1 or more");
        end
    endgenerate

    state_t          state;
    state_t          state_nxt;
    logic            fall_stb;
    logic            end_stb;
    logic            pending;
    logic            accept;
    logic            complete;
    logic            res_done;
    logic [RC_W-1:0] res_cnt;

    phi2_gen #(
        .DIV(DIV)
    ) u_phi2_gen (
        .clk      (clk),
        .rst      (rst),
        .phi2     (phi2_o),
        .fall_stb (fall_stb),
        .end_stb  (end_stb)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // The fall that completes a cycle also retires it, so a new command can
    // be taken on that same clk and the bus never idles between commands.
    always_comb begin
        state_nxt = state;
        pending   = (state == CYCLE) && !fall_stb;
        cmd_ready = (state != RESET) && fall_stb && !pending;
        accept    = cmd_ready && cmd_valid;
        complete  = (state == CYCLE) && fall_stb;
        res_done  = (state == RESET) && fall_stb && (res_cnt == RES_LAST);
        case (state)
            RESET: begin
                if (res_done) begin
                    state_nxt = IDLE;
                end
            end
            IDLE, CYCLE: begin
                if (fall_stb) begin
                    state_nxt = accept ? CYCLE : IDLE;
                end
            end
            default: state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt   <= '0;
            res_n_o   <= 1'b0;
            rw_o      <= 1'b1;
            rs0_o     <= 1'b0;
            addr_o    <= '0;
            db_o      <= '0;
            db_oe     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_we    <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            rsp_valid <= complete;
            if ((state == RESET) && fall_stb) begin
                res_cnt <= res_cnt + 1'b1;
            end
            if (res_done) begin
                res_n_o <= 1'b1;
            end
            // rw_o still describes the cycle that is finishing here
            if (complete) begin
                rsp_we <= !rw_o;
                if (rw_o) begin
                    rsp_rdata <= db_i;
                end
            end
            if (accept) begin
                addr_o <= cmd_addr;
                rs0_o  <= cmd_rs0;
                rw_o   <= !cmd_we;
                db_oe  <= cmd_we;
                if (cmd_we) begin
                    db_o <= cmd_wdata;
                end
            end else if (fall_stb && (state != RESET)) begin
                rw_o  <= 1'b1;
                db_oe <= 1'b0;
            end
            if (accept) begin
                busy <= 1'b1;
            end else if (complete) begin
                busy <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) end_stb |-> !phi2_o);

endmodule
